// File: rtl/encoder_8b10b.sv
// encoder_8b10b: transmit-side 8b/10b encoder with registered 10-bit output and running
// disparity (RD) tracking. Illegal K requests are encoded as data and flagged.
// Optional feature: define ENCODER_IDLE_COMMA_EN to emit K28.5 idle commas when
// valid_in = 0; otherwise the outputs hold during idle cycles.
// Output bit order is j h g f i e d c b a = [9:0]; bit 0 (a) goes on the wire first.
module encoder_8b10b (
   input  logic       clk,
   input  logic       reset_L,
   input  logic [7:0] data8_in,
   input  logic       k_in,
   input  logic       valid_in,
   output logic [9:0] data10_out,
   output logic       valid_out,
   output logic       rd_out,
   output logic       k_err_out
);

   logic [9:0] data10_q, data10_d;
   logic       valid_q, valid_d;
   logic       rd_q, rd_d;
   logic       k_err_q, k_err_d;

   logic [7:0] enc_byte;
   logic       enc_k;
   logic [4:0] x;
   logic [2:0] y;
   logic       k_legal;
   logic [5:0] c6_neg, c6;     // abcdei, a in bit 5
   logic [3:0] c4_neg, c4;     // fghj, f in bit 3
   logic       unbal6, unbal4;
   logic       rd_mid, rd_fin, use_a7;
   logic [9:0] enc_code;

   // Idle cycles present K28.5 to the encoder; only used when idle commas are enabled.
   always_comb begin
      enc_byte = valid_in ? data8_in : 8'hBC;
      enc_k    = valid_in ? k_in : 1'b1;
   end

   // Combinational 5b/6b then 3b/4b encode from the current RD.
   always_comb begin
      x = enc_byte[4:0];
      y = enc_byte[7:5];
      k_legal = enc_k && ((x == 5'd28) ||
                          ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                           (x == 5'd29) || (x == 5'd30))));

      // RD- column of the 5b/6b table
      unique case (x)
         5'd0:  c6_neg = 6'b100111;
         5'd1:  c6_neg = 6'b011101;
         5'd2:  c6_neg = 6'b101101;
         5'd3:  c6_neg = 6'b110001;
         5'd4:  c6_neg = 6'b110101;
         5'd5:  c6_neg = 6'b101001;
         5'd6:  c6_neg = 6'b011001;
         5'd7:  c6_neg = 6'b111000;
         5'd8:  c6_neg = 6'b111001;
         5'd9:  c6_neg = 6'b100101;
         5'd10: c6_neg = 6'b010101;
         5'd11: c6_neg = 6'b110100;
         5'd12: c6_neg = 6'b001101;
         5'd13: c6_neg = 6'b101100;
         5'd14: c6_neg = 6'b011100;
         5'd15: c6_neg = 6'b010111;
         5'd16: c6_neg = 6'b011011;
         5'd17: c6_neg = 6'b100011;
         5'd18: c6_neg = 6'b010011;
         5'd19: c6_neg = 6'b110010;
         5'd20: c6_neg = 6'b001011;
         5'd21: c6_neg = 6'b101010;
         5'd22: c6_neg = 6'b011010;
         5'd23: c6_neg = 6'b111010;
         5'd24: c6_neg = 6'b110011;
         5'd25: c6_neg = 6'b100110;
         5'd26: c6_neg = 6'b010110;
         5'd27: c6_neg = 6'b110110;
         5'd28: c6_neg = k_legal ? 6'b001111 : 6'b001110;
         5'd29: c6_neg = 6'b101110;
         5'd30: c6_neg = 6'b011110;
         default: c6_neg = 6'b101011;
      endcase

      // RD+ column is the complement for unbalanced codes and for D.7's 111000/000111 pair
      unbal6 = ($countones(c6_neg) != 3);
      c6     = (rd_q && (unbal6 || (x == 5'd7))) ? ~c6_neg : c6_neg;
      rd_mid = rd_q ^ unbal6;

      use_a7 = rd_mid ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                      : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));

      if (k_legal) begin
         // K28 4b codes are all RD-/RD+ complements; K.x.7 always use A7
         if (x == 5'd28) begin
            unique case (y)
               3'd0: c4_neg = 4'b1011;
               3'd1: c4_neg = 4'b0110;
               3'd2: c4_neg = 4'b1010;
               3'd3: c4_neg = 4'b1100;
               3'd4: c4_neg = 4'b1101;
               3'd5: c4_neg = 4'b0101;
               3'd6: c4_neg = 4'b1001;
               default: c4_neg = 4'b0111;
            endcase
         end else begin
            c4_neg = 4'b0111;
         end
         unbal4 = ($countones(c4_neg) != 2);
         c4     = rd_mid ? ~c4_neg : c4_neg;
      end else begin
         unique case (y)
            3'd0: c4_neg = 4'b1011;
            3'd1: c4_neg = 4'b1001;
            3'd2: c4_neg = 4'b0101;
            3'd3: c4_neg = 4'b1100;
            3'd4: c4_neg = 4'b1101;
            3'd5: c4_neg = 4'b1010;
            3'd6: c4_neg = 4'b0110;
            default: c4_neg = use_a7 ? 4'b0111 : 4'b1110;
         endcase
         unbal4 = ($countones(c4_neg) != 2);
         // D.x.3 is balanced but still alternates 1100/0011 with RD
         c4     = (rd_mid && (unbal4 || (y == 3'd3))) ? ~c4_neg : c4_neg;
      end

      rd_fin   = rd_mid ^ unbal4;
      enc_code = {c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
   end

   // Next-state selection between a new symbol, an idle comma, or a hold.
   always_comb begin
      data10_d = data10_q;
      rd_d     = rd_q;
      valid_d  = 1'b0;
      k_err_d  = 1'b0;
      if (valid_in) begin
         data10_d = enc_code;
         rd_d     = rd_fin;
         valid_d  = 1'b1;
         k_err_d  = k_in && !k_legal;
      end else begin
`ifdef ENCODER_IDLE_COMMA_EN
         data10_d = enc_code;
         rd_d     = rd_fin;
`endif
      end
   end

   // Output and RD registers.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         data10_q <= 10'h000;
         valid_q  <= 1'b0;
         rd_q     <= 1'b0;
         k_err_q  <= 1'b0;
      end else begin
         data10_q <= data10_d;
         valid_q  <= valid_d;
         rd_q     <= rd_d;
         k_err_q  <= k_err_d;
      end
   end

   assign data10_out = data10_q;
   assign valid_out  = valid_q;
   assign rd_out     = rd_q;
   assign k_err_out  = k_err_q;

endmodule

// File: tb/tb_encoder_8b10b.sv
// tb_encoder_8b10b: directed vectors plus randomized stream checked against a table-driven
// reference model of the 8b/10b code.
module tb_encoder_8b10b;

   logic       clk = 1'b0;
   logic       reset_L = 1'b1;
   logic [7:0] data8_in = 8'h00;
   logic       k_in = 1'b0;
   logic       valid_in = 1'b0;
   logic [9:0] data10_out;
   logic       valid_out;
   logic       rd_out;
   logic       k_err_out;

   encoder_8b10b dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .data8_in  (data8_in),
      .k_in      (k_in),
      .valid_in  (valid_in),
      .data10_out(data10_out),
      .valid_out (valid_out),
      .rd_out    (rd_out),
      .k_err_out (k_err_out)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // Full two-column tables, abcdei / fghj written in transmit order (first bit leftmost).
   logic [5:0] t6n [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   logic [5:0] t6p [32] = '{
      6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
      6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
      6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
      6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
   logic [3:0] t4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110,
                           4'b1110};
   logic [3:0] t4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110,
                           4'b0001};
   logic [3:0] k4n [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001,
                           4'b0111};
   logic [3:0] k4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110,
                           4'b1000};
   logic [7:0] k_list [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                               8'hF7, 8'hFB, 8'hFD, 8'hFE};

   logic       m_rd = 1'b0;
   logic [9:0] m_data = 10'h000;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // RD after a sub-block follows from its disparity: more ones -> RD+, fewer -> RD-.
   function automatic logic rd_after(input int ones, input int half, input logic rd);
      if (ones > half) return 1'b1;
      if (ones < half) return 1'b0;
      return rd;
   endfunction

   task automatic model(input logic [7:0] b, input logic k, input logic rd,
                        output logic [9:0] code, output logic rd_o, output logic kerr);
      int         x, y, ones;
      logic       legal, rd_m, a7;
      logic [5:0] c6;
      logic [3:0] c4;
      logic [9:0] tx;
      x = int'(b[4:0]);
      y = int'(b[7:5]);
      legal = k && (x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
      kerr = k && !legal;
      c6 = rd ? t6p[x] : t6n[x];
      if (legal && x == 28) c6 = rd ? 6'b110000 : 6'b001111;
      ones = 0;
      for (int i = 0; i < 6; i++) ones += int'(c6[i]);
      rd_m = rd_after(ones, 3, rd);
      if (legal) begin
         if (x == 28) c4 = rd_m ? k4p[y] : k4n[y];
         else         c4 = rd_m ? 4'b1000 : 4'b0111;
      end else if (y == 7) begin
         a7 = (!rd_m && (x == 17 || x == 18 || x == 20)) ||
              (rd_m && (x == 11 || x == 13 || x == 14));
         if (a7) c4 = rd_m ? 4'b1000 : 4'b0111;
         else    c4 = rd_m ? 4'b0001 : 4'b1110;
      end else begin
         c4 = rd_m ? t4p[y] : t4n[y];
      end
      ones = 0;
      for (int i = 0; i < 4; i++) ones += int'(c4[i]);
      rd_o = rd_after(ones, 2, rd_m);
      tx = {c6, c4};
      for (int i = 0; i < 10; i++) code[i] = tx[9 - i];
   endtask

   task automatic step(input logic [7:0] b, input logic k, input logic v);
      logic [9:0] code;
      logic       rdn, ke;
      @(negedge clk);
      data8_in = b;
      k_in     = k;
      valid_in = v;
      @(posedge clk);
      #1;
      if (v) begin
         model(b, k, m_rd, code, rdn, ke);
         m_data = code;
         m_rd   = rdn;
      end else begin
         ke = 1'b0;
`ifdef ENCODER_IDLE_COMMA_EN
         model(8'hBC, 1'b1, m_rd, code, rdn, ke);
         m_data = code;
         m_rd   = rdn;
`endif
      end
      check_eq("data10", 32'(data10_out), 32'(m_data));
      check_eq("rd", 32'(rd_out), 32'(m_rd));
      check_eq("valid", 32'(valid_out), 32'(v));
      check_eq("k_err", 32'(k_err_out), 32'(ke));
   endtask

   // Short asynchronous reset pulse between clock edges; outputs must clear at once.
   task automatic pulse_reset();
      reset_L = 1'b0;
      #1;
      check_eq("rst_data10", 32'(data10_out), 32'h0);
      check_eq("rst_valid", 32'(valid_out), 32'h0);
      check_eq("rst_rd", 32'(rd_out), 32'h0);
      check_eq("rst_k_err", 32'(k_err_out), 32'h0);
      #2;
      reset_L = 1'b1;
      m_rd   = 1'b0;
      m_data = 10'h000;
   endtask

   initial begin
      logic [7:0] b;
      logic       k, v;
      int         r;
      #1;
      reset_L = 1'b0;
      #10;
      check_eq("init_data10", 32'(data10_out), 32'h0);
      check_eq("init_valid", 32'(valid_out), 32'h0);
      check_eq("init_rd", 32'(rd_out), 32'h0);
      check_eq("init_k_err", 32'(k_err_out), 32'h0);
      reset_L = 1'b1;

      step(8'h00, 1'b0, 1'b1);
      check_eq("d0.0_code", 32'(data10_out), 32'h0B9);
      step(8'hBC, 1'b1, 1'b1);
      check_eq("k28.5_a", 32'(data10_out), 32'h17C);
      step(8'hBC, 1'b1, 1'b1);
      check_eq("k28.5_b", 32'(data10_out), 32'h283);
      step(8'hB5, 1'b0, 1'b1);
      check_eq("d21.5", 32'(data10_out), 32'h155);
      step(8'hF1, 1'b0, 1'b1);
      check_eq("d17.7_a7", 32'(data10_out), 32'h3B1);
      check_eq("d17.7_rd", 32'(rd_out), 32'h1);

      step(8'h00, 1'b0, 1'b0);
`ifdef ENCODER_IDLE_COMMA_EN
      check_eq("idle1", 32'(data10_out), 32'h283);
`else
      check_eq("idle1", 32'(data10_out), 32'h3B1);
`endif
      step(8'h00, 1'b0, 1'b0);
`ifdef ENCODER_IDLE_COMMA_EN
      check_eq("idle2", 32'(data10_out), 32'h17C);
`else
      check_eq("idle2", 32'(data10_out), 32'h3B1);
      check_eq("idle2_rd", 32'(rd_out), 32'h1);
`endif

      // K28.5 from RD+ lands at RD-, then an illegal K request
      step(8'hBC, 1'b1, 1'b1);
      step(8'h00, 1'b1, 1'b1);
      check_eq("illegal_k_code", 32'(data10_out), 32'h0B9);
      check_eq("illegal_k_flag", 32'(k_err_out), 32'h1);

      step(8'hBC, 1'b1, 1'b1);
      check_eq("pre_reset_rd", 32'(rd_out), 32'h1);
      pulse_reset();
      step(8'h00, 1'b0, 1'b1);
      check_eq("post_reset_d0.0", 32'(data10_out), 32'h0B9);

      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 9));
         b = 8'($urandom);
         k = 1'b0;
         if (r < 2) begin
            b = k_list[$urandom_range(0, 11)];
            k = 1'b1;
         end else if (r == 2) begin
            k = 1'b1;
         end
         v = ($urandom_range(0, 7) != 0);
         step(b, k, v);
         if ($urandom_range(0, 199) == 0) pulse_reset();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
